// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - line-granular memory responder with fixed latency and gnt pulse
// Build option LINE_MEM_INIT_EN: array starts as word i of line a = a*LINE_SIZE + i.
module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int LATENCY       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [31:0]         wr_line [1<<LINE_ADDR_LEN],
  output logic [31:0]         rd_line [1<<LINE_ADDR_LEN],
  output logic                gnt
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int DEPTH     = 1 << ADDR_LEN;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

`ifdef LINE_MEM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [7:0]          r_cnt;
  logic [ADDR_LEN-1:0] r_addr;
  logic                r_is_wr;
  logic [31:0]         r_wr_line [LINE_SIZE];
  logic [31:0]         r_rd_line [LINE_SIZE];
  logic                w_accept;
  logic                w_done;

  // The array holds data XOR the power-up pattern, so a zero start state reads back as the pattern.
  logic [31:0] r_mem [DEPTH][LINE_SIZE] = '{default: '{default: '0}};

  function automatic logic [31:0] init_word(input logic [ADDR_LEN-1:0] a, input int i);
    return INIT_EN ? 32'({a, LINE_ADDR_LEN'(i)}) : 32'd0;
  endfunction

  assign w_accept = (r_state == IDLE) && (rd_req || wr_req);
  assign w_done   = (r_state == BUSY) && (r_cnt == 8'd0);
  assign gnt      = (r_state == RESP);
  assign rd_line  = r_rd_line;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (rd_req || wr_req) w_next_state = BUSY;
      BUSY:    if (r_cnt == 8'd0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_addr    <= '0;
      r_is_wr   <= 1'b0;
      r_rd_line <= '{default: '0};
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr  <= addr;
        r_is_wr <= wr_req;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == BUSY && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_done && !r_is_wr) begin
        for (int i = 0; i < LINE_SIZE; i++)
          r_rd_line[i] <= r_mem[r_addr][i] ^ init_word(r_addr, i);
      end
    end
  end

  // Reset never touches the line buffer or the array; a reset mid-write leaves the FSM in IDLE so nothing commits.
  always_ff @(posedge clk) begin
    if (w_accept && wr_req)
      r_wr_line <= wr_line;
    if (w_done && r_is_wr) begin
      for (int i = 0; i < LINE_SIZE; i++)
        r_mem[r_addr][i] <= r_wr_line[i] ^ init_word(r_addr, i);
    end
  end

endmodule
